rackctl_txctl_sm: RTL and testbench

- Initiator (TURF-side) end of the RACKctl mode0 link. Takes one 24-bit address + 32-bit data transaction and serializes it onto the bidirectional RACKCTL line, then turns the line around and deserializes the 32-bit response from the SURF-side responder.
- Runs entirely in rackclk. The owner supplies transactions from its command path and instantiates the differential IOBUFDS outside this block.

---
 rtl/rackctl_txctl_sm.sv | 197 +++++++++++++++++++
 tb/tb_rackctl_txctl_sm.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rackctl_txctl_sm.sv
// RACKctl mode0 initiator. Serializes one 24-bit address + 32-bit data frame
// onto the shared RACKCTL line, releases the line, then collects the
// responder's start bit and 32-bit reply. All logic runs in rackclk.
module rackctl_txctl_sm #(
  parameter logic        INV        = 1'b0,
  parameter int unsigned TURNAROUND = 2,
  parameter int unsigned TIMEOUT    = 1024
) (
  input  logic        rackclk_i,
  input  logic        rst_n_i,
  input  logic [23:0] txn_addr_i,
  input  logic [31:0] txn_data_i,
  input  logic        txn_valid_i,
  output logic        txn_ready_o,
  output logic [31:0] resp_data_o,
  output logic        resp_valid_o,
  output logic        resp_err_o,
  output logic        rack_o,
  output logic        rack_oe_o,
  input  logic        rack_i,
  output logic        busy_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_SHIFT,
    S_TURN,
    S_WAIT,
    S_RESP,
    S_DONE
  } state_t;

  localparam logic [5:0]  C_SHIFT_LAST   = 6'd55;
  localparam logic [5:0]  C_RESP_LAST    = 6'd31;
  localparam logic [5:0]  C_TURN_LAST    = 6'(TURNAROUND - 1);
  localparam logic [15:0] C_TIMEOUT_LAST = 16'(TIMEOUT - 1);

  state_t      r_state;
  state_t      w_next;
  logic [55:0] r_tx_sh;
  logic [5:0]  r_cnt;
  logic [15:0] r_to;
  logic [31:0] r_rx_sh;
  logic [31:0] r_resp_data;
  logic        r_resp_err;

  logic        w_rx;
  logic        w_line;
  logic        w_oe;
  logic        w_ready;
  logic        w_valid;
  logic        w_timeout;
  logic        w_state_chg;
  logic [31:0] w_rx_next;

  assign w_rx        = rack_i ^ INV;
  assign w_state_chg = (w_next != r_state);
  assign w_rx_next   = {r_rx_sh[30:0], w_rx};

  // State register.
  always_ff @(posedge rackclk_i) begin
    if (!rst_n_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode and state-decoded line/handshake outputs.
  always_comb begin
    w_next    = r_state;
    w_line    = 1'b0;
    w_oe      = 1'b1;
    w_ready   = 1'b0;
    w_valid   = 1'b0;
    w_timeout = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_ready = 1'b1;
        if (txn_valid_i) begin
          w_next = S_START;
        end
      end
      S_START: begin
        w_line = 1'b1;
        w_next = S_SHIFT;
      end
      S_SHIFT: begin
        w_line = r_tx_sh[55];
        if (r_cnt == C_SHIFT_LAST) begin
          w_next = S_TURN;
        end
      end
      S_TURN: begin
        w_oe = 1'b0;
        if (r_cnt == C_TURN_LAST) begin
          w_next = S_WAIT;
        end
      end
      S_WAIT: begin
        w_oe = 1'b0;
        if (w_rx) begin
          w_next = S_RESP;
        end else if (r_to == C_TIMEOUT_LAST) begin
          w_next    = S_DONE;
          w_timeout = 1'b1;
        end
      end
      S_RESP: begin
        w_oe = 1'b0;
        if (r_cnt == C_RESP_LAST) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        w_valid = 1'b1;
        w_next  = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Phase counter: restarts at every state change, so SHIFT, TURN and RESP
  // each see it count from zero.
  always_ff @(posedge rackclk_i) begin
    if (!rst_n_i) begin
      r_cnt <= '0;
    end else if (w_state_chg) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 6'd1;
    end
  end

  // Start-bit timeout counter: cleared entering TURN and when the start bit
  // arrives, advanced on each idle WAIT cycle.
  always_ff @(posedge rackclk_i) begin
    if (!rst_n_i) begin
      r_to <= '0;
    end else if (r_state == S_SHIFT && w_next == S_TURN) begin
      r_to <= '0;
    end else if (r_state == S_WAIT) begin
      if (w_rx) begin
        r_to <= '0;
      end else begin
        r_to <= r_to + 16'd1;
      end
    end
  end

  // Outgoing frame: load on acceptance, shift MSB-first during SHIFT.
  always_ff @(posedge rackclk_i) begin
    if (!rst_n_i) begin
      r_tx_sh <= '0;
    end else if (r_state == S_IDLE && txn_valid_i) begin
      r_tx_sh <= {txn_addr_i, txn_data_i};
    end else if (r_state == S_SHIFT) begin
      r_tx_sh <= {r_tx_sh[54:0], 1'b0};
    end
  end

  // Incoming reply: LSB-in shift so the first sampled bit lands at bit 31.
  always_ff @(posedge rackclk_i) begin
    if (!rst_n_i) begin
      r_rx_sh <= '0;
    end else if (r_state == S_RESP) begin
      r_rx_sh <= w_rx_next;
    end
  end

  // Response holding register: updated only on the way into DONE so the
  // visible word is stable between pulses while RESP is still shifting.
  always_ff @(posedge rackclk_i) begin
    if (!rst_n_i) begin
      r_resp_data <= '0;
      r_resp_err  <= 1'b0;
    end else if (w_timeout) begin
      r_resp_data <= '0;
      r_resp_err  <= 1'b1;
    end else if (r_state == S_RESP && r_cnt == C_RESP_LAST) begin
      r_resp_data <= w_rx_next;
      r_resp_err  <= 1'b0;
    end
  end

  assign txn_ready_o  = w_ready;
  assign busy_o       = (r_state != S_IDLE);
  assign resp_valid_o = w_valid;
  assign resp_data_o  = r_resp_data;
  assign resp_err_o   = r_resp_err;
  assign rack_oe_o    = w_oe;
  assign rack_o       = w_line ^ INV;

endmodule

// File: tb/tb_rackctl_txctl_sm.sv
// Bench for rackctl_txctl_sm: two instances (INV=0/TIMEOUT=16 and
// INV=1/TIMEOUT=1024), directed transactions, a scoreboard of expected
// responses popped by a monitor whenever resp_valid_o is seen.
module tb_rackctl_txctl_sm;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst_n   [2];
  logic [23:0] addr    [2];
  logic [31:0] wdata   [2];
  logic        valid   [2];
  logic        ready   [2];
  logic [31:0] rdata   [2];
  logic        rvalid  [2];
  logic        rerr    [2];
  logic        rack_o  [2];
  logic        rack_oe [2];
  logic        rack_i  [2];
  logic        busy    [2];

  genvar g;
  generate
    for (g = 0; g < 2; g++) begin : g_dut
      rackctl_txctl_sm #(
        .INV       (g == 1 ? 1'b1 : 1'b0),
        .TURNAROUND(2),
        .TIMEOUT   (g == 0 ? 16 : 1024)
      ) u_dut (
        .rackclk_i   (clk),
        .rst_n_i     (rst_n[g]),
        .txn_addr_i  (addr[g]),
        .txn_data_i  (wdata[g]),
        .txn_valid_i (valid[g]),
        .txn_ready_o (ready[g]),
        .resp_data_o (rdata[g]),
        .resp_valid_o(rvalid[g]),
        .resp_err_o  (rerr[g]),
        .rack_o      (rack_o[g]),
        .rack_oe_o   (rack_oe[g]),
        .rack_i      (rack_i[g]),
        .busy_o      (busy[g])
      );
    end
  endgenerate

  typedef struct {
    logic [31:0] d;
    logic        e;
    int          c;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int n_chk = 0;
  int n_err = 0;

  function automatic logic inv(input int i);
    return (i == 1);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  task automatic push(input int i, input logic [31:0] d, input logic e, input int c);
    exp_t x;
    x.d = d; x.e = e; x.c = c;
    if (i == 0) q0.push_back(x);
    else        q1.push_back(x);
  endtask

  function automatic int qsize(input int i);
    return (i == 0) ? q0.size() : q1.size();
  endfunction

  // Monitor: every resp_valid_o pulse must match the oldest expected entry.
  always @(negedge clk) begin : mon
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      if (rvalid[i] === 1'b1) begin
        if (qsize(i) == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL unexpected_resp_valid: inst %0d got resp_valid=1 required 0 (cycle %0d)", i, cyc);
        end else begin
          if (i == 0) e = q0.pop_front();
          else        e = q1.pop_front();
          chk("resp_data", 64'(rdata[i]), 64'(e.d));
          chk("resp_err", 64'(rerr[i]), 64'(e.e));
          if (e.c >= 0) chk("resp_cycle", 64'(cyc), 64'(e.c));
        end
      end
    end
  end

  // Present a transaction; acc = cycle index of the START cycle, -1 if never accepted.
  task automatic start_txn(input int i, input logic [23:0] a, input logic [31:0] d,
                           input bit hold, output int acc);
    bit got;
    got = 1'b0;
    acc = -1;
    @(negedge clk);
    addr[i] = a; wdata[i] = d; valid[i] = 1'b1;
    for (int k = 0; k < 300; k++) begin
      if (ready[i] === 1'b1) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("accept_seen", 64'(got), 64'd1);
    if (got) begin
      @(posedge clk);
      #1;
      acc = cyc;
    end
    if (!hold) valid[i] = 1'b0;
  endtask

  // Check the outgoing frame, act as responder, and check DONE line state.
  task automatic serve(input int i, input logic [23:0] a, input logic [31:0] d, input int acc,
                       input bit answer, input logic [31:0] resp, input int delay, output int done);
    logic [55:0] fr;
    int bad;
    int w;
    fr = {a, d};
    w = acc + 59;
    done = answer ? (w + delay + 33) : (w + 16);
    push(i, answer ? resp : 32'h0, !answer, done);
    bad = 0;
    @(negedge clk);
    if (!(rack_oe[i] === 1'b1 && (rack_o[i] ^ inv(i)) === 1'b1)) bad++;
    for (int k = 0; k < 56; k++) begin
      @(negedge clk);
      if (!(rack_oe[i] === 1'b1 && (rack_o[i] ^ inv(i)) === fr[55-k])) bad++;
    end
    chk("tx_frame_bad_bits", 64'(bad), 64'd0);
    bad = 0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      if (rack_oe[i] !== 1'b0) bad++;
    end
    chk("turn_released", 64'(bad), 64'd0);
    bad = 0;
    if (answer) begin
      for (int k = 0; k < delay; k++) begin
        @(negedge clk);
        rack_i[i] = inv(i);
        if (rack_oe[i] !== 1'b0) bad++;
      end
      @(negedge clk);
      rack_i[i] = ~inv(i);
      if (rack_oe[i] !== 1'b0) bad++;
      for (int k = 0; k < 32; k++) begin
        @(negedge clk);
        rack_i[i] = resp[31-k] ^ inv(i);
        if (rack_oe[i] !== 1'b0) bad++;
      end
    end else begin
      for (int k = 0; k < 16; k++) begin
        @(negedge clk);
        rack_i[i] = inv(i);
        if (rack_oe[i] !== 1'b0) bad++;
      end
    end
    chk("line_released_in_wait_resp", 64'(bad), 64'd0);
    @(negedge clk);
    rack_i[i] = inv(i);
    chk("done_oe", 64'(rack_oe[i]), 64'd1);
    chk("done_line", 64'(rack_o[i] ^ inv(i)), 64'd0);
  endtask

  task automatic drain(input int i);
    for (int k = 0; k < 100; k++) begin
      if (qsize(i) == 0) break;
      @(negedge clk);
    end
    chk("response_arrived", 64'(qsize(i)), 64'd0);
  endtask

  task automatic full_txn(input int i, input logic [23:0] a, input logic [31:0] d,
                          input bit answer, input logic [31:0] resp, input int delay);
    int acc;
    int done;
    start_txn(i, a, d, 1'b0, acc);
    if (acc >= 0) begin
      serve(i, a, d, acc, answer, resp, delay, done);
      drain(i);
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin : main
    int acc1, acc2, done1, done2;
    for (int i = 0; i < 2; i++) begin
      rst_n[i] = 1'b0; valid[i] = 1'b1; addr[i] = 24'hFFFFFF;
      wdata[i] = 32'hFFFFFFFF; rack_i[i] = inv(i);
    end

    // Reset held with a pending request.
    repeat (5) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_ready", 64'(ready[i]), 64'd1);
      chk("rst_oe", 64'(rack_oe[i]), 64'd1);
      chk("rst_line", 64'(rack_o[i] ^ inv(i)), 64'd0);
      chk("rst_rack_o_phys", 64'(rack_o[i]), 64'(inv(i)));
      chk("rst_busy", 64'(busy[i]), 64'd0);
      chk("rst_resp_data", 64'(rdata[i]), 64'd0);
      chk("rst_resp_err", 64'(rerr[i]), 64'd0);
      chk("rst_resp_valid", 64'(rvalid[i]), 64'd0);
      valid[i] = 1'b0; rst_n[i] = 1'b1;
    end
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("post_rst_no_capture", 64'(busy[i]), 64'd0);
    end

    // Write, INV=0, immediate start bit.
    full_txn(0, 24'h012345, 32'hCAFEF00D, 1'b1, 32'hCAFEF00D, 0);
    // Read, INV=1, start bit in the 4th WAIT cycle.
    full_txn(1, 24'h800010, 32'h00000000, 1'b1, 32'h00000001, 3);
    // Timeout (TIMEOUT=16), then a normal transaction.
    full_txn(0, 24'h800055, 32'h0BADF00D, 1'b0, 32'h0, 0);
    full_txn(0, 24'h00ABCD, 32'h12345678, 1'b1, 32'hA5A55A5A, 1);

    // Reset asserted during SHIFT bit 20.
    start_txn(0, 24'h0F0F0F, 32'h3C3C3C3C, 1'b0, acc1);
    if (acc1 >= 0) begin
      repeat (22) @(negedge clk);
      chk("midop_busy_before_reset", 64'(busy[0]), 64'd1);
      rst_n[0] = 1'b0;
      @(negedge clk);
      chk("midop_oe", 64'(rack_oe[0]), 64'd1);
      chk("midop_line", 64'(rack_o[0] ^ inv(0)), 64'd0);
      chk("midop_ready", 64'(ready[0]), 64'd1);
      rst_n[0] = 1'b1;
      repeat (100) @(negedge clk);
    end
    full_txn(0, 24'h123456, 32'h87654321, 1'b1, 32'hDEADBEEF, 2);

    // Back-to-back: valid held high across two words.
    start_txn(1, 24'h000111, 32'h11111111, 1'b1, acc1);
    if (acc1 >= 0) begin
      addr[1] = 24'h800222; wdata[1] = 32'h22222222;
      serve(1, 24'h000111, 32'h11111111, acc1, 1'b1, 32'h0F0F0F0F, 0, done1);
      start_txn(1, 24'h800222, 32'h22222222, 1'b0, acc2);
      chk("b2b_accept_cycle", 64'(acc2), 64'(done1 + 2));
      if (acc2 >= 0) begin
        serve(1, 24'h800222, 32'h22222222, acc2, 1'b1, 32'hF0F0F0F0, 0, done2);
      end
      drain(1);
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", 64'(q0.size() + q1.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
